// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the far end of a core load/store port.
// One request is accepted at a time over a valid/ready handshake; each accepted
// request produces exactly one response LATENCY cycles after the accept edge.
// Stores write byte/halfword/word lanes of a word-organised array; loads return
// the selected lane sign- or zero-extended following RV32I funct3 encoding.
// Misaligned, out-of-range and illegal-funct3 accesses return rsp_err=1 with
// rsp_rdata=0 and leave memory untouched.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_funct3 in   RV32I load/store funct3
//   req_addr   in   byte address
//   req_wdata  in   store data, right-aligned
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_rdata  out  extended load result; 0 for stores and errors
//   rsp_err    out  request rejected
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Last counter value spent in WAIT; WAIT is never entered when LATENCY==1.
  localparam logic [1:0] CNT_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        en_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          accept;
  logic          range_err, align_err, f3_err, acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_val;
  logic [3:0]    wmask;
  logic [31:0]   wdata_rep;

  // req_ready stays low through reset and rises on the first edge after release.
  assign req_ready = en_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign idx = req_addr[AW+1:2];
  assign off = req_addr[1:0];

  // Access decode and error classification.
  always_comb begin
    range_err = |req_addr[31:AW+2];
    align_err = 1'b0;
    case (req_funct3[1:0])
      2'b01:   align_err = off[0];
      2'b10:   align_err = |off;
      default: align_err = 1'b0;
    endcase
    if (req_we) begin
      f3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      f3_err = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end
    acc_err = range_err || align_err || f3_err;
  end

  // Load lane select and extension.
  always_comb begin
    rd_word = mem_q[idx];
    rd_byte = rd_word[{off, 3'b000} +: 8];
    rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_val = rd_word;
      3'b100:  ld_val = {24'h000000, rd_byte};
      3'b101:  ld_val = {16'h0000, rd_half};
      default: ld_val = '0;
    endcase
  end

  // Store lane mask; data is replicated so every lane sees its bytes.
  always_comb begin
    wmask     = 4'b0000;
    wdata_rep = req_wdata;
    case (req_funct3)
      3'b000: begin
        wmask     = 4'b0001 << off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        wmask     = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        wmask     = 4'b1111;
        wdata_rep = req_wdata;
      end
      default: begin
        wmask     = 4'b0000;
        wdata_rep = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_we || acc_err) ? '0 : ld_val;
          err_d   = acc_err;
          cnt_d   = '0;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept && req_we && !acc_err) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (wmask[l]) begin
          mem_q[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=1 (a) and
// one with LATENCY=3 (b). Expected responses are queued at issue time and
// popped by per-instance monitors on each response handshake.
module tb_dmem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(32), .LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? b_req_ready : a_req_ready;
  endfunction

  function automatic logic get_valid(input bit sel);
    return sel ? b_rsp_valid : a_rsp_valid;
  endfunction

  function automatic logic get_rsp_ready(input bit sel);
    return sel ? b_rsp_ready : a_rsp_ready;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic we,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      b_req_valid = v; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
    end else begin
      a_req_valid = v; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
    end
  endtask

  // Called #1 after a rising edge. Returns #1 after the response handshake
  // edge when rsp_ready is high, otherwise at the negedge rsp_valid is seen.
  task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int   n;
    exp_t e;
    drive(sel, 1'b1, we, f3, addr, wd);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (sel) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_ready_wait", {31'b0, get_ready(sel)}, 32'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_valid(sel) && n < 20);
    chk(sel ? "b_latency" : "a_latency", n, exp_lat);
    if (get_rsp_ready(sel)) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst && a_rsp_valid && a_rsp_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rsp_rdata, e.rdata);
        chk("a_err", {31'b0, a_rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst && b_rsp_valid && b_rsp_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rsp_rdata, e.rdata);
        chk("b_err", {31'b0, b_rsp_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_a_req_ready", {31'b0, a_req_ready}, 32'd0);
    chk("rst_a_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_a_rsp_err", {31'b0, a_rsp_err}, 32'd0);
    chk("rst_b_req_ready", {31'b0, b_req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_a_req_ready_pre_edge", {31'b0, a_req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_a_req_ready", {31'b0, a_req_ready}, 32'd1);
    chk("rel_b_req_ready", {31'b0, b_req_ready}, 32'd1);

    // LW of cleared memory, latency 1.
    issue(1'b0, 1'b0, F_W, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1);

    // Sign/zero extension.
    issue(1'b0, 1'b1, F_W,  32'h10, 32'h8000_00F1, 32'h0, 1'b0, 1);
    issue(1'b0, 1'b0, F_B,  32'h10, 32'h0, 32'hFFFF_FFF1, 1'b0, 1);
    issue(1'b0, 1'b0, F_BU, 32'h10, 32'h0, 32'h0000_00F1, 1'b0, 1);
    issue(1'b0, 1'b0, F_H,  32'h12, 32'h0, 32'hFFFF_8000, 1'b0, 1);
    issue(1'b0, 1'b0, F_HU, 32'h12, 32'h0, 32'h0000_8000, 1'b0, 1);

    // Partial-lane stores.
    issue(1'b0, 1'b1, F_W, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 1);
    issue(1'b0, 1'b1, F_B, 32'hB, 32'h0000_00AA, 32'h0, 1'b0, 1);
    issue(1'b0, 1'b1, F_H, 32'h8, 32'h0000_BEEF, 32'h0, 1'b0, 1);
    issue(1'b0, 1'b0, F_W, 32'h8, 32'h0, 32'hAA22_BEEF, 1'b0, 1);
    issue(1'b0, 1'b0, F_BU, 32'h9, 32'h0, 32'h0000_00BE, 1'b0, 1);

    // Error cases leave memory intact.
    issue(1'b0, 1'b1, F_W, 32'h4, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    issue(1'b0, 1'b1, F_H, 32'h5, 32'h0000_FFFF, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b0, F_W, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b0, F_B, 32'h80, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b1, 3'b011, 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b1, F_W, 32'h8000_0004, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b0, F_W, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0, 1);

    // Latency 3 with back-pressure.
    issue(1'b1, 1'b1, F_W, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 3);
    b_rsp_ready = 1'b0;
    issue(1'b1, 1'b0, F_H, 32'h20, 32'h0, 32'h0000_5678, 1'b0, 3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'b0, b_rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", b_rsp_rdata, 32'h0000_5678);
      chk("bp_rsp_err", {31'b0, b_rsp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, b_req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    b_rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready_before", {31'b0, b_req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("hs_req_ready_after", {31'b0, b_req_ready}, 32'd1);
    chk("hs_rsp_valid_after", {31'b0, b_rsp_valid}, 32'd0);

    // Reset while in WAIT drops the transaction and clears memory.
    issue(1'b1, 1'b1, F_W, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
    drive(1'b1, 1'b1, 1'b0, F_W, 32'h8, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("wait_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
    chk("wait_req_ready", {31'b0, b_req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, b_req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    chk("midrst_no_rsp", {31'b0, b_rsp_valid}, 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_b_req_ready", {31'b0, b_req_ready}, 32'd1);
    chk("post_rst_a_req_ready", {31'b0, a_req_ready}, 32'd1);
    issue(1'b1, 1'b0, F_W, 32'h8, 32'h0, 32'h0, 1'b0, 3);
    issue(1'b0, 1'b0, F_W, 32'h8, 32'h0, 32'h0, 1'b0, 1);

    repeat (3) @(posedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake.
- Stores perform byte, halfword or word writes into a word-organised array. Loads return data sign- or zero-extended per RV32I funct3.
- Each request gets exactly one response after a programmable latency; error status covers misaligned, out-of-range and illegal accesses.

Parameters:
- DEPTH, 32, number of 32-bit words (power of two, 2..1024).
- LATENCY, 1, cycles from request accept to rsp_valid (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request rejected; no memory change.

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=0 while reset is asserted, 1 the first clk edge after release; rsp_valid=0; rsp_rdata=0; rsp_err=0; latency counter=0; all DEPTH words cleared to 0. A reset mid-transaction drops the transaction; no response is ever issued for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. An accept (req_valid&&req_ready at a rising edge) moves to WAIT if LATENCY>1, otherwise to RESP.
  - WAIT: counter counts LATENCY-1 cycles, then moves to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_valid&&rsp_ready, then return to IDLE.
- Timing: rsp_valid rises exactly LATENCY cycles after the accept edge. req_ready is 0 in WAIT and RESP; only one request is outstanding. The earliest next accept is the edge after the response handshake; there is no same-cycle bypass.
- Decode: word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
- Error conditions (checked at accept):
  - any bit of req_addr above the word index is 1;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
  - On error: rsp_err=1, rsp_rdata=0, memory unchanged.
- Stores (funct3 000 SB, 001 SH, 010 SW):
  - SB writes req_wdata[7:0] to byte lane addr[1:0].
  - SH writes req_wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes the full word.
  - The write commits on the accept edge; other lanes are untouched. rsp_rdata=0, rsp_err=0.
- Loads:
  - The word is read on the accept edge; the selected lane is captured into the response register.
  - LB (000) and LH (001) sign-extend.
  - LW (010) returns the word.
  - LBU (100) and LHU (101) zero-extend.
- Ordering: a load accepted after a store's response handshake observes the stored data.
- rsp_ready may be held high before rsp_valid. A response is never dropped or duplicated. A req_valid change while req_ready=0 is ignored.

Test Plan:
- Reset then LW addr 0x0 -> rsp_valid exactly 1 cycle after accept (LATENCY=1), rsp_rdata=0x00000000, rsp_err=0.
- SW 0x8000_00F1 @0x10, then LB @0x10 -> 0xFFFF_FFF1; LBU @0x10 -> 0x0000_00F1; LH @0x12 -> 0xFFFF_8000; LHU @0x12 -> 0x0000_8000.
- SW 0x11223344 @0x8, SB 0xAA @0xB, SH 0xBEEF @0x8 -> LW @0x8 returns 0xAA22BEEF.
- SH @0x5, LW @0x6, LB @0x80 (DEPTH=32), and load funct3=011 -> each gives rsp_err=1 and rsp_rdata=0; a subsequent LW @0x4 still returns the prior contents.
- LATENCY=3, rsp_ready held low 5 cycles -> rsp_valid rises 3 cycles after accept, data stable throughout, req_ready=0 until the cycle after the handshake.
- rst pulled low while in WAIT -> rsp_valid=0 immediately; after release, req_ready=1 and LW @0x8 returns 0.
